// File: rtl/mprj_checkpoint_monitor.sv
// rtl/mprj_checkpoint_monitor.sv - ordered GPIO checkpoint signature monitor
//
// Purpose: watches an asynchronous checkbit bus for an ordered sequence of
// NUM_STEPS signature codes. The bus is synchronised and glitch filtered
// before use. The monitor reports progress, pass, fail (abort code) and
// watchdog timeout.
//
// Ports:
//   wb_clk_i     clock
//   wb_rst_i     asynchronous active-high reset
//   start_i      one-cycle pulse; arms the monitor and clears results
//   bus_i        asynchronous checkbit bus (DATA_W)
//   exp_codes_i  expected codes; step k at [k*DATA_W +: DATA_W]
//   busy_o       high while ARMED or RUN
//   step_o       number of codes matched so far
//   started_o    first code matched
//   pass_o       all codes matched in order
//   fail_o       FAIL_CODE accepted
//   timeout_o    watchdog expired
//   cycles_o     cycles since start, frozen at the terminal event
//
// Optional: define MPRJ_CHECKPOINT_STAMP_EN to add stamp_sel_i (3) and
// stamp_o (TIMEOUT_W), a per-step capture of cycles_o at each match.
module mprj_checkpoint_monitor #(
  parameter int                DATA_W         = 16,
  parameter int                NUM_STEPS      = 2,
  parameter int                STABLE_CYCLES  = 2,
  parameter int                TIMEOUT_W      = 24,
  parameter int                TIMEOUT_CYCLES = 75000,
  parameter logic [DATA_W-1:0] FAIL_CODE      = DATA_W'(16'hAB6F)
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          start_i,
  input  logic [DATA_W-1:0]             bus_i,
  input  logic [NUM_STEPS*DATA_W-1:0]   exp_codes_i,
`ifdef MPRJ_CHECKPOINT_STAMP_EN
  input  logic [2:0]                    stamp_sel_i,
  output logic [TIMEOUT_W-1:0]          stamp_o,
`endif
  output logic                          busy_o,
  output logic [3:0]                    step_o,
  output logic                          started_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic                          timeout_o,
  output logic [TIMEOUT_W-1:0]          cycles_o
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [3:0]           STABLE_N  = 4'(STABLE_CYCLES);
  localparam logic [3:0]           LAST_STEP = 4'(NUM_STEPS - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                   WD_EN     = (TIMEOUT_CYCLES != 0);

  state_t               state;
  logic [DATA_W-1:0]    sync1, sync2, hold_val;
  logic [3:0]           stab_cnt, stab_next;
  logic                 changed, accept;
  logic                 is_fail, is_match, wd_hit, active;
  logic [TIMEOUT_W-1:0] cyc_inc;
  logic [DATA_W-1:0]    codes [8];

  // Unused table slots read as zero so step_o can index directly.
  for (genvar k = 0; k < 8; k++) begin : g_codes
    if (k < NUM_STEPS) begin : g_used
      assign codes[k] = exp_codes_i[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign codes[k] = '0;
    end
  end

  // Stability counter saturates at STABLE_N; the accept pulse fires only on
  // the cycle it first reaches STABLE_N, so a held value fires once.
  always_comb begin
    changed   = 1'b0;
    stab_next = stab_cnt;
    accept    = 1'b0;
    changed   = (sync2 != hold_val);
    if (changed)
      stab_next = 4'd1;
    else if (stab_cnt != STABLE_N)
      stab_next = stab_cnt + 4'd1;
    accept = (stab_next == STABLE_N) && (changed || (stab_cnt != STABLE_N));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1    <= '0;
      sync2    <= '0;
      hold_val <= '0;
      stab_cnt <= '0;
    end else begin
      sync1    <= bus_i;
      sync2    <= sync1;
      hold_val <= sync2;
      stab_cnt <= stab_next;
    end
  end

  assign active   = (state == S_ARMED) || (state == S_RUN);
  assign is_fail  = accept && (sync2 == FAIL_CODE);
  assign is_match = accept && (sync2 == codes[step_o[2:0]]);
  // >= so a match landing on the limit cycle cannot skip past the watchdog.
  assign wd_hit   = WD_EN && (cycles_o >= TO_LAST);
  assign cyc_inc  = (&cycles_o) ? cycles_o : cycles_o + TIMEOUT_W'(1);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      busy_o    <= 1'b0;
      step_o    <= '0;
      started_o <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
      cycles_o  <= '0;
    end else if (start_i) begin
      state     <= S_ARMED;
      busy_o    <= 1'b1;
      step_o    <= '0;
      started_o <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
      cycles_o  <= '0;
    end else if (active) begin
      if (is_fail) begin
        state  <= S_FAIL;
        fail_o <= 1'b1;
        busy_o <= 1'b0;
      end else if (is_match) begin
        started_o <= 1'b1;
        step_o    <= step_o + 4'd1;
        if (step_o == LAST_STEP) begin
          state  <= S_PASS;
          pass_o <= 1'b1;
          busy_o <= 1'b0;
        end else begin
          state    <= S_RUN;
          cycles_o <= cyc_inc;
        end
      end else if (wd_hit) begin
        state     <= S_TIMEOUT;
        timeout_o <= 1'b1;
        busy_o    <= 1'b0;
      end else begin
        cycles_o <= cyc_inc;
      end
    end
  end

`ifdef MPRJ_CHECKPOINT_STAMP_EN
  logic [TIMEOUT_W-1:0] stamps [8];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 8; i++) stamps[i] <= '0;
    end else if (start_i) begin
      for (int i = 0; i < 8; i++) stamps[i] <= '0;
    end else if (active && !is_fail && is_match) begin
      stamps[step_o[2:0]] <= cycles_o;
    end
  end

  assign stamp_o = ({1'b0, stamp_sel_i} < 4'(NUM_STEPS)) ? stamps[stamp_sel_i] : '0;
`endif

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// tb/tb_mprj_checkpoint_monitor.sv - self-checking bench for mprj_checkpoint_monitor
module tb_mprj_checkpoint_monitor;

  localparam int DW = 16;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] bus = '0;
  logic          start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic          busy_a, started_a, pass_a, fail_a, timeout_a;
  logic [3:0]    step_a;
  logic [TW-1:0] cycles_a;
  logic          busy_b, started_b, pass_b, fail_b, timeout_b;
  logic [3:0]    step_b;
  logic [TW-1:0] cycles_b;
  logic          busy_c, started_c, pass_c, fail_c, timeout_c;
  logic [3:0]    step_c;
  logic [TW-1:0] cycles_c;
`ifdef MPRJ_CHECKPOINT_STAMP_EN
  logic [2:0]    sel_a = '0, sel_b = '0, sel_c = '0;
  logic [TW-1:0] stamp_a, stamp_b, stamp_c;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mprj_checkpoint_monitor u_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_a), .bus_i(bus),
    .exp_codes_i({16'hAB61, 16'hAB60}),
`ifdef MPRJ_CHECKPOINT_STAMP_EN
    .stamp_sel_i(sel_a), .stamp_o(stamp_a),
`endif
    .busy_o(busy_a), .step_o(step_a), .started_o(started_a), .pass_o(pass_a),
    .fail_o(fail_a), .timeout_o(timeout_a), .cycles_o(cycles_a));

  mprj_checkpoint_monitor #(.TIMEOUT_CYCLES(100)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_b), .bus_i(bus),
    .exp_codes_i({16'hAB61, 16'hAB60}),
`ifdef MPRJ_CHECKPOINT_STAMP_EN
    .stamp_sel_i(sel_b), .stamp_o(stamp_b),
`endif
    .busy_o(busy_b), .step_o(step_b), .started_o(started_b), .pass_o(pass_b),
    .fail_o(fail_b), .timeout_o(timeout_b), .cycles_o(cycles_b));

  mprj_checkpoint_monitor #(.NUM_STEPS(3)) u_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_c), .bus_i(bus),
    .exp_codes_i({16'hAB62, 16'hAB61, 16'hAB60}),
`ifdef MPRJ_CHECKPOINT_STAMP_EN
    .stamp_sel_i(sel_c), .stamp_o(stamp_c),
`endif
    .busy_o(busy_c), .step_o(step_c), .started_o(started_c), .pass_o(pass_c),
    .fail_o(fail_c), .timeout_o(timeout_c), .cycles_o(cycles_c));

  // Start edge is the posedge after start is raised; es = cyc seen after it.
  task automatic start_a_pulse(output int es);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0; es = cyc;
  endtask

  task automatic test_reset();
    int e;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy_a, step_a, started_a, pass_a, fail_a, timeout_a} !== 9'd0) begin n_err++; $display("FAIL reset_flags_a got=%0h exp=0", {busy_a, step_a, started_a, pass_a, fail_a, timeout_a}); end
    n_cmp++; if (cycles_a !== '0) begin n_err++; $display("FAIL reset_cycles_a got=%0d exp=0", cycles_a); end
    e = int'(busy_b) + int'(busy_c) + int'(timeout_b) + int'(pass_c);
    n_cmp++; if (e !== 0) begin n_err++; $display("FAIL reset_other got=%0d exp=0", e); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_pass();
    int es, cd;
    start_a_pulse(es);
    n_cmp++; if (busy_a !== 1'b1 || step_a !== 4'd0 || cycles_a !== '0) begin n_err++; $display("FAIL pass_armed got=%0b/%0d/%0d exp=1/0/0", busy_a, step_a, cycles_a); end
    bus = 16'hAB60; cd = cyc; exp_q.push_back(1);
    repeat (3) @(negedge clk);
    n_cmp++; if (started_a !== 1'b0) begin n_err++; $display("FAIL pass_early_start got=%0b exp=0", started_a); end
    @(negedge clk);
    n_cmp++; if (started_a !== 1'b1) begin n_err++; $display("FAIL pass_latency got=%0b exp=1", started_a); end
    e_chk_step_a: begin
      int ev; ev = exp_q.pop_front();
      n_cmp++; if (step_a !== 4'(ev)) begin n_err++; $display("FAIL pass_step1 got=%0d exp=%0d", step_a, ev); end
    end
    n_cmp++; if (cycles_a !== TW'(cd + 4 - es)) begin n_err++; $display("FAIL pass_cycles_run got=%0d exp=%0d", cycles_a, cd + 4 - es); end
    repeat (6) @(negedge clk);
    bus = 16'hAB61; cd = cyc; exp_q.push_back(2);
    repeat (10) @(negedge clk);
    begin
      int ev; ev = exp_q.pop_front();
      n_cmp++; if (step_a !== 4'(ev)) begin n_err++; $display("FAIL pass_step2 got=%0d exp=%0d", step_a, ev); end
    end
    n_cmp++; if ({pass_a, busy_a, started_a, fail_a} !== 4'b1010) begin n_err++; $display("FAIL pass_flags got=%b exp=1010", {pass_a, busy_a, started_a, fail_a}); end
    n_cmp++; if (cycles_a !== TW'(cd + 3 - es)) begin n_err++; $display("FAIL pass_cycles_frozen got=%0d exp=%0d", cycles_a, cd + 3 - es); end
  endtask

  task automatic test_glitch();
    int es, ev;
    bus = 16'h0000; repeat (8) @(negedge clk);
    start_a_pulse(es);
    bus = 16'hAB60; exp_q.push_back(0);
    @(negedge clk);
    bus = 16'h0000;
    repeat (10) @(negedge clk);
    ev = exp_q.pop_front();
    n_cmp++; if (step_a !== 4'(ev)) begin n_err++; $display("FAIL glitch_step got=%0d exp=%0d", step_a, ev); end
    n_cmp++; if ({busy_a, started_a, pass_a} !== 3'b100) begin n_err++; $display("FAIL glitch_flags got=%b exp=100", {busy_a, started_a, pass_a}); end
    n_cmp++; if (cycles_a !== TW'(cyc - es)) begin n_err++; $display("FAIL glitch_cycles got=%0d exp=%0d", cycles_a, cyc - es); end
  endtask

  task automatic test_abort();
    int es, cd, ev;
    logic [TW-1:0] snap;
    start_a_pulse(es);   // restart while busy
    n_cmp++; if (cycles_a !== '0 || busy_a !== 1'b1) begin n_err++; $display("FAIL abort_restart got=%0d/%0b exp=0/1", cycles_a, busy_a); end
    bus = 16'hAB60; exp_q.push_back(1);
    repeat (10) @(negedge clk);
    ev = exp_q.pop_front();
    n_cmp++; if (step_a !== 4'(ev)) begin n_err++; $display("FAIL abort_step1 got=%0d exp=%0d", step_a, ev); end
    bus = 16'hAB6F; cd = cyc;
    repeat (10) @(negedge clk);
    n_cmp++; if ({fail_a, pass_a, busy_a, step_a} !== {3'b100, 4'd1}) begin n_err++; $display("FAIL abort_flags got=%b exp=1000001", {fail_a, pass_a, busy_a, step_a}); end
    n_cmp++; if (cycles_a !== TW'(cd + 3 - es)) begin n_err++; $display("FAIL abort_cycles got=%0d exp=%0d", cycles_a, cd + 3 - es); end
    snap = TW'(cd + 3 - es);
    repeat (5) @(negedge clk);
    n_cmp++; if (cycles_a !== snap || fail_a !== 1'b1) begin n_err++; $display("FAIL abort_sticky got=%0d/%0b exp=%0d/1", cycles_a, fail_a, snap); end
  endtask

  task automatic test_timeout();
    int es;
    bus = 16'h0000; repeat (8) @(negedge clk);
    start_b = 1'b1; @(negedge clk); start_b = 1'b0; es = cyc;
    for (int i = 0; i < 200 && !timeout_b; i++) @(negedge clk);
    n_cmp++; if (timeout_b !== 1'b1) begin n_err++; $display("FAIL timeout_seen got=%0b exp=1", timeout_b); end
    n_cmp++; if (cyc - es !== 100) begin n_err++; $display("FAIL timeout_latency got=%0d exp=100", cyc - es); end
    n_cmp++; if (cycles_b !== TW'(99) || busy_b !== 1'b0) begin n_err++; $display("FAIL timeout_cycles got=%0d/%0b exp=99/0", cycles_b, busy_b); end
  endtask

  task automatic test_order();
    logic [DW-1:0] seq [4];
    int ev;
    seq[0] = 16'hAB62; seq[1] = 16'hAB60; seq[2] = 16'hAB61; seq[3] = 16'hAB62;
    bus = 16'h0000; repeat (8) @(negedge clk);
    start_c = 1'b1; @(negedge clk); start_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus = seq[i]; exp_q.push_back(i);
      repeat (10) @(negedge clk);
      ev = exp_q.pop_front();
      n_cmp++; if (step_c !== 4'(ev)) begin n_err++; $display("FAIL order_step%0d got=%0d exp=%0d", i, step_c, ev); end
      n_cmp++; if (pass_c !== (i == 3) || started_c !== (i != 0)) begin n_err++; $display("FAIL order_flags%0d got=%0b%0b exp=%0b%0b", i, pass_c, started_c, i == 3, i != 0); end
    end
  endtask

  task automatic test_reset_midrun();
    int es, cd1, cd2, ev;
    bus = 16'h0000; repeat (8) @(negedge clk);
    start_a_pulse(es);
    bus = 16'hAB60; repeat (10) @(negedge clk);
    n_cmp++; if (step_a !== 4'd1) begin n_err++; $display("FAIL midrun_pre got=%0d exp=1", step_a); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({busy_a, step_a, started_a, pass_a, fail_a, timeout_a} !== 9'd0 || cycles_a !== '0) begin n_err++; $display("FAIL midrun_async got=%0h/%0d exp=0/0", {busy_a, step_a, started_a, pass_a, fail_a, timeout_a}, cycles_a); end
    @(negedge clk); rst = 1'b0;
    bus = 16'h0000; repeat (8) @(negedge clk);
    start_a_pulse(es);
    bus = 16'hAB60; cd1 = cyc; repeat (10) @(negedge clk);
    bus = 16'hAB61; cd2 = cyc; exp_q.push_back(2); repeat (10) @(negedge clk);
    ev = exp_q.pop_front();
    n_cmp++; if (step_a !== 4'(ev) || pass_a !== 1'b1) begin n_err++; $display("FAIL midrun_repass got=%0d/%0b exp=%0d/1", step_a, pass_a, ev); end
`ifdef MPRJ_CHECKPOINT_STAMP_EN
    sel_a = 3'd0; #1;
    n_cmp++; if (stamp_a !== TW'(cd1 + 3 - es)) begin n_err++; $display("FAIL stamp0 got=%0d exp=%0d", stamp_a, cd1 + 3 - es); end
    sel_a = 3'd1; #1;
    n_cmp++; if (stamp_a !== TW'(cd2 + 3 - es)) begin n_err++; $display("FAIL stamp1 got=%0d exp=%0d", stamp_a, cd2 + 3 - es); end
    sel_a = 3'd2; #1;
    n_cmp++; if (stamp_a !== '0) begin n_err++; $display("FAIL stamp_oob got=%0d exp=0", stamp_a); end
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_pass();
    test_glitch();
    test_abort();
    test_timeout();
    test_order();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mprj_checkpoint_monitor.md
Name: mprj_checkpoint_monitor

Overview:
- Hardware checkpoint monitor that watches a user-project GPIO checkbit bus for an ordered sequence of signature codes.
- Reports progress, pass, fail and timeout; generalises the fixed two-code started/passed check to N steps of configurable width.
- Adds input synchronisation, glitch filtering, an abort code and a cycle-accurate watchdog.
- Sits in the user project area on the wishbone clock; outputs feed LA inputs and status GPIOs.

Parameters:
- DATA_W, 16, width of the monitored checkbit bus.
- NUM_STEPS, 2, number of ordered expected codes (1..8).
- STABLE_CYCLES, 2, consecutive identical synchronised samples required before a value is accepted (1..15).
- TIMEOUT_W, 24, watchdog counter width.
- TIMEOUT_CYCLES, 75000, cycles from start to timeout; 0 disables the watchdog.
- FAIL_CODE, 16'hAB6F, abort signature; only the low DATA_W bits are used.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle pulse; arms the monitor and clears results.
- bus_i  in  DATA_W  asynchronous checkbit bus from pads.
- exp_codes_i  in  NUM_STEPS*DATA_W  expected codes; step k occupies bits [k*DATA_W +: DATA_W]; quasi-static while busy.
- busy_o  out  1  high while in ARMED or RUN.
- step_o  out  4  number of codes matched so far.
- started_o  out  1  first code matched.
- pass_o  out  1  all codes matched in order.
- fail_o  out  1  FAIL_CODE accepted.
- timeout_o  out  1  watchdog expired.
- cycles_o  out  TIMEOUT_W  cycles elapsed since start; frozen at the terminal event.

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser and filter cleared.
- Input path: 2-flop synchroniser, then a stability filter. The filter counter resets whenever the synchronised value changes. A value becomes "accepted" once it has held for STABLE_CYCLES samples.
- Acceptance latency: 2 + STABLE_CYCLES cycles from a bus change.
- An accepted event fires once per distinct value. Holding a value does not re-fire it; the filter must see a change first.
- States: IDLE, ARMED, RUN, PASS, FAIL, TIMEOUT.
- IDLE: start_i moves to ARMED. cycles_o, step_o and all flags clear in the same edge.
- ARMED:
  - Accepted value == code[0]: go to RUN, step_o=1, started_o=1.
  - If NUM_STEPS==1, code[0] goes directly to PASS with started_o=1 and pass_o=1.
- RUN:
  - Accepted value == code[step_o]: step_o increments.
  - When the final code matches, go to PASS with pass_o=1.
- ARMED/RUN, FAIL_CODE accepted: go to FAIL, fail_o=1. FAIL_CODE takes priority over a match if it also equals an expected code.
- ARMED/RUN, any other accepted value: ignored, no state change.
- Watchdog:
  - cycles_o increments every cycle in ARMED/RUN, saturating at all-ones.
  - When cycles_o reaches TIMEOUT_CYCLES-1 with no terminal event, the next state is TIMEOUT with timeout_o=1.
  - A match or fail on that same cycle wins over timeout.
- PASS/FAIL/TIMEOUT are sticky: outputs hold and busy_o=0. Only start_i (re-arm, with clear) or reset leaves them.
- start_i while busy: restarts from ARMED, clears step_o and cycles_o. The filter is not cleared.
- Async reset mid-run: immediately returns to IDLE with all outputs 0.
- Flags are registered; each flag asserts on the clock edge after the acceptance event.

Optional Feature:
- Macro: MPRJ_CHECKPOINT_STAMP_EN.
- Defined: adds ports stamp_sel_i (in, 3) and stamp_o (out, TIMEOUT_W).
  - One register per step captures cycles_o at the cycle its code matches.
  - stamp_o returns entry stamp_sel_i combinationally.
  - All entries clear on reset and on start_i.
  - Selecting an index >= NUM_STEPS returns 0.
- Undefined: the ports and registers do not exist; core behaviour is identical.

Test Plan:
- Defaults, exp codes {AB61,AB60}. Start, drive bus AB60 then AB61, each held 10 cycles -> started_o after 4 cycles, then pass_o, step_o=2, busy_o=0.
- Glitch: STABLE_CYCLES=2, 1-cycle pulse of AB60 between 0000 values -> no acceptance, step_o stays 0.
- Abort: after AB60, drive AB6F -> fail_o=1, pass_o=0, step_o=1, cycles_o frozen.
- Timeout: TIMEOUT_CYCLES=100, start with bus held 0000 -> timeout_o=1 exactly 100 cycles after start, cycles_o=99.
- Order: NUM_STEPS=3, codes AB60/AB61/AB62, drive AB62, AB60, AB61, AB62 -> first AB62 ignored, pass_o after the final AB62.
- Reset mid-run: assert wb_rst_i at step_o=1 -> all outputs 0 asynchronously. Restart then passes normally; with STAMP_EN, stamp_o reports the match cycle counts.
